// File: rtl/cfg_master.sv
`default_nettype none
// ============================================================================
// cfg_master : 3-byte 8N1 command serializer and 2-byte response receiver
// Rev 1.0
// ============================================================================
module cfg_master #(
  parameter int BAUD_DIV = 543
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] cmd_data,
  input  logic        snd_frm,
  input  logic        RX_C,
  output logic        TX_C,
  output logic [15:0] resp,
  output logic        rsp_rdy
);

  localparam logic [1:0]  S_IDLE  = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;
  localparam logic [1:0]  R_IDLE  = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;
  localparam logic [15:0] c_div_m1  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] c_half_m1 = 16'(BAUD_DIV / 2 - 1);

  logic [1:0]  tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [1:0]  tx_byte_q, tx_byte_d;
  logic [23:0] tx_shadow_q, tx_shadow_d;
  logic        tx_line_q, tx_line_d;

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]  rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rsp_cnt_q, rsp_cnt_d;
  logic [7:0]  rsp_hold_q, rsp_hold_d;
  logic [15:0] resp_q, resp_d;
  logic        rdy_q, rdy_d;

  logic        w_tx_launch, w_tx_bit_end;
  logic [7:0]  w_tx_cur;
  logic [2:0]  w_tx_bit_nxt;
  logic        w_rx_fall, w_byte_ok, w_frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= 16'd0;
      tx_bit_q    <= 3'd0;
      tx_byte_q   <= 2'd0;
      tx_shadow_q <= 24'd0;
      tx_line_q   <= 1'b1;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= R_IDLE;
      rx_cnt_q    <= 16'd0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'd0;
      rsp_cnt_q   <= 1'b0;
      rsp_hold_q  <= 8'd0;
      resp_q      <= 16'd0;
      rdy_q       <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_byte_q   <= tx_byte_d;
      tx_shadow_q <= tx_shadow_d;
      tx_line_q   <= tx_line_d;
      rx_s1_q     <= RX_C;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rsp_cnt_q   <= rsp_cnt_d;
      rsp_hold_q  <= rsp_hold_d;
      resp_q      <= resp_d;
      rdy_q       <= rdy_d;
    end
  end

  // The line value is computed from the next state so TX_C stays registered
  // yet changes on the same edge as the state.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q + 16'd1;
    tx_bit_d    = tx_bit_q;
    tx_byte_d   = tx_byte_q;
    tx_shadow_d = tx_shadow_q;
    tx_line_d   = tx_line_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = 16'd0;
        if (w_tx_launch) begin
          tx_state_d  = S_START;
          tx_byte_d   = 2'd0;
          tx_shadow_d = cmd_data;
          tx_line_d   = 1'b0;
        end
      end
      S_START: begin
        if (w_tx_bit_end) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 3'd0;
          tx_line_d  = w_tx_cur[0];
        end
      end
      S_DATA: begin
        if (w_tx_bit_end) begin
          tx_cnt_d = 16'd0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d  = w_tx_bit_nxt;
            tx_line_d = w_tx_cur[w_tx_bit_nxt];
          end
        end
      end
      default: begin
        if (w_tx_bit_end) begin
          tx_cnt_d = 16'd0;
          if (tx_byte_q == 2'd2) begin
            tx_state_d = S_IDLE;
            tx_line_d  = 1'b1;
          end else begin
            tx_state_d = S_START;
            tx_byte_d  = tx_byte_q + 2'd1;
            tx_line_d  = 1'b0;
          end
        end
      end
    endcase
  end

  always_comb begin
    w_tx_launch  = (tx_state_q == S_IDLE) && snd_frm;
    w_tx_bit_end = (tx_cnt_q == c_div_m1);
    w_tx_bit_nxt = tx_bit_q + 3'd1;
    case (tx_byte_q)
      2'd0:    w_tx_cur = tx_shadow_q[23:16];
      2'd1:    w_tx_cur = tx_shadow_q[15:8];
      default: w_tx_cur = tx_shadow_q[7:0];
    endcase
    TX_C = tx_line_q;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      R_IDLE: begin
        rx_cnt_d = 16'd0;
        if (w_rx_fall) rx_state_d = R_START;
      end
      R_START: begin
        if (rx_cnt_q == c_half_m1) begin
          rx_cnt_d   = 16'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rx_cnt_q == c_div_m1) begin
          rx_cnt_d   = 16'd0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
        end
      end
      default: begin
        if (rx_cnt_q == c_div_m1) begin
          rx_cnt_d   = 16'd0;
          rx_state_d = R_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    w_rx_fall   = rx_prev_q && !rx_s2_q;
    w_byte_ok   = (rx_state_q == R_STOP) && (rx_cnt_q == c_div_m1) && rx_s2_q;
    w_frame_err = (rx_state_q == R_STOP) && (rx_cnt_q == c_div_m1) && !rx_s2_q;
    resp        = resp_q;
    rsp_rdy     = rdy_q;
  end

  // Completion wins over a simultaneous launch for delivery; the launch
  // still leaves the byte counter cleared for the next response.
  always_comb begin
    rsp_cnt_d  = rsp_cnt_q;
    rsp_hold_d = rsp_hold_q;
    resp_d     = resp_q;
    rdy_d      = 1'b0;
    if (w_byte_ok) begin
      if (rsp_cnt_q) begin
        resp_d    = {rsp_hold_q, rx_shift_q};
        rdy_d     = 1'b1;
        rsp_cnt_d = 1'b0;
      end else begin
        rsp_hold_d = rx_shift_q;
        rsp_cnt_d  = 1'b1;
      end
    end
    if (w_frame_err || w_tx_launch) rsp_cnt_d = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_cfg_master.sv
`default_nettype none
// ============================================================================
// tb_cfg_master : scoreboard bench for cfg_master (line decoder + RX model)
// Rev 1.0
// ============================================================================
module tb_cfg_master;
  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] cmd_data = 24'd0;
  logic        snd_frm = 1'b0;
  logic        RX_C = 1'b1;
  logic        TX_C;
  logic [15:0] resp;
  logic        rsp_rdy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0]  tx_exp[$];
  int          launch_exp[$];
  logic [15:0] rsp_exp[$];

  cfg_master #(.BAUD_DIV(DIV)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_data (cmd_data),
    .snd_frm  (snd_frm),
    .RX_C     (RX_C),
    .TX_C     (TX_C),
    .resp     (resp),
    .rsp_rdy  (rsp_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [23:0] d);
    cmd_data = d;
    snd_frm  = 1'b1;
    tx_exp.push_back(d[23:16]);
    tx_exp.push_back(d[15:8]);
    tx_exp.push_back(d[7:0]);
    launch_exp.push_back(cyc + 1);
    @(negedge clk);
    snd_frm = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic stop);
    RX_C = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX_C = b[i];
      repeat (DIV) @(negedge clk);
    end
    RX_C = stop;
    repeat (DIV) @(negedge clk);
    RX_C = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic rx_pair(input logic [7:0] a, input logic [7:0] b);
    rsp_exp.push_back({a, b});
    rx_byte(a, 1'b1);
    rx_byte(b, 1'b1);
  endtask

  // Line decoder: samples every TX bit at its midpoint.
  bit         mon_busy = 1'b0;
  int         mon_t, mon_n = 0, mon_k, last_start = 0;
  logic [7:0] mon_b;
  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 1'b0;
      mon_n    = 0;
    end else if (!mon_busy) begin
      if (TX_C === 1'b0) begin
        mon_busy = 1'b1;
        mon_t    = 0;
        if (mon_n % 3 == 0) begin
          chk("tx_launch_expected", launch_exp.size() != 0, 1);
          if (launch_exp.size() != 0) chk("tx_start_cycle", cyc, launch_exp.pop_front());
        end else begin
          chk("tx_byte_spacing", cyc - last_start, 10 * DIV);
        end
        last_start = cyc;
      end
    end else begin
      mon_t++;
      if (mon_t == DIV / 2) begin
        chk("tx_start_bit", TX_C, 0);
      end else if (mon_t > DIV / 2 && (mon_t - DIV / 2) % DIV == 0) begin
        mon_k = (mon_t - DIV / 2) / DIV;
        if (mon_k <= 8) begin
          mon_b[mon_k - 1] = TX_C;
        end else begin
          chk("tx_stop_bit", TX_C, 1);
          chk("tx_byte_expected", tx_exp.size() != 0, 1);
          if (tx_exp.size() != 0) chk("tx_byte", mon_b, tx_exp.pop_front());
          mon_n++;
          mon_busy = 1'b0;
        end
      end
    end
  end

  logic        prev_rdy = 1'b0;
  logic [15:0] last_resp = 16'd0;
  always @(negedge clk) begin
    if (rsp_rdy === 1'b1) begin
      chk("rdy_single_cycle", prev_rdy, 0);
      chk("rsp_expected", rsp_exp.size() != 0, 1);
      if (rsp_exp.size() != 0) chk("resp_word", resp, rsp_exp.pop_front());
    end else if (!rst && resp !== last_resp) begin
      chk("resp_stable", resp, last_resp);
    end
    prev_rdy  = rsp_rdy;
    last_resp = resp;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    repeat (2) @(negedge clk);
    chk("rst_tx", TX_C, 1);
    chk("rst_resp", resp, 16'h0000);
    chk("rst_rdy", rsp_rdy, 0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("idle_tx", TX_C, 1);
    chk("idle_rdy", rsp_rdy, 0);

    // Command frame, an ignored mid-frame strobe, then a launch on the first idle cycle
    c0 = cyc;
    send(24'h0A1234);
    repeat (99) @(negedge clk);
    cmd_data = 24'hFFFFFF;
    snd_frm  = 1'b1;
    @(negedge clk);
    snd_frm  = 1'b0;
    while (cyc < c0 + 481) @(negedge clk);
    send(24'h5A3C96);
    repeat (500) @(negedge clk);

    rx_pair(8'h0A, 8'h5A);
    rx_pair(8'h05, 8'hA5);
    repeat (20) @(negedge clk);

    // Echo: response arrives while the command is still on the wire
    fork
      send(24'h001ABC);
      begin
        repeat (40) @(negedge clk);
        rx_pair(8'h1A, 8'hBC);
      end
    join
    repeat (150) @(negedge clk);
    chk("echo_resp", resp[13:0], 14'h1ABC);

    RX_C = 1'b0;
    repeat (5) @(negedge clk);
    RX_C = 1'b1;
    repeat (40) @(negedge clk);
    rx_pair(8'h5C, 8'h3E);

    // Half-response, then a framing error must reset the byte counter
    rx_byte(8'h77, 1'b1);
    rx_byte(8'hEE, 1'b0);
    rx_pair(8'h12, 8'h34);
    repeat (20) @(negedge clk);
    chk("frame_err_resp", resp, 16'h1234);

    // Reset during byte 1 (bit1 of 0xA5 is low on the line)
    send(24'hC3A55A);
    repeat (10 * DIV + 39) @(negedge clk);
    chk("pre_rst_tx", TX_C, 0);
    rst = 1'b1;
    tx_exp.delete();
    launch_exp.delete();
    @(negedge clk);
    chk("mid_rst_tx", TX_C, 1);
    chk("mid_rst_resp", resp, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(24'h5AC3E1);
    repeat (500) @(negedge clk);

    chk("tx_pending", tx_exp.size(), 0);
    chk("rsp_pending", rsp_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cfg_master.md
# cfg_master

Configuration-link master for the `cbc_dig` bench environment. On a one-cycle `snd_frm` strobe it serializes a 24-bit command onto `TX_C` as three 8N1 UART bytes. It independently receives a two-byte response on `RX_C`, assembles it into a 16-bit word and pulses `rsp_rdy`. It stands in for the host that programs set-points and EEPROM-command traffic into the DUT's configuration UART.

## Interface
- `BAUD_DIV`, default 543: clock cycles per UART bit (approximately 921.6 kbaud at 500 MHz); legal range 4..65535.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_data`  in  24  command word; captured on the `snd_frm` cycle.
- `snd_frm`  in  1  one-cycle strobe that launches a 3-byte frame.
- `RX_C`  in  1  serial response input, idle high; asynchronous to `clk`.
- `TX_C`  out  1  serial command output, idle high.
- `resp`  out  16  last complete response word.
- `rsp_rdy`  out  1  one-cycle pulse when `resp` is updated.

## Operation
- Line format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- Transmit path:
  - States: IDLE, START, DATA, STOP.
  - In IDLE, `snd_frm`=1 latches `cmd_data` into a shadow register and zeroes the byte index.
  - Byte order: `cmd_data[23:16]`, then `[15:8]`, then `[7:0]`.
  - Bytes go back-to-back: the STOP of byte n is followed directly by the START of byte n+1, with no idle bits.
  - After the third STOP, return to IDLE.
  - `snd_frm` outside IDLE is ignored; it neither restarts the frame nor changes the shadow register.
- Receive path, independent of transmit:
  - `RX_C` passes through a 2-flop synchronizer.
  - A high-to-low transition starts a bit timer, and `RX_C` is sampled at `BAUD_DIV/2` (integer division).
  - If the line is high at that first sample, it is a false start: discard and return to idle hunt.
  - Otherwise, sample 8 data bits and then the stop bit, each `BAUD_DIV` cycles apart.
  - Stop bit 0 (framing error): discard the byte and reset the response byte counter to 0.
- Response assembly:
  - The first good byte goes to a holding register as `resp[15:8]`.
  - The second good byte completes the word: `resp` <= {held byte, second byte} and `rsp_rdy` pulses.
  - The byte counter then returns to 0.
  - A transmit launch (`snd_frm` accepted in IDLE) also clears the response byte counter, so stale half-responses are dropped.
- `resp` holds its value until the next completed response; it changes only in the `rsp_rdy` cycle.

## Timing
- Reset values: `TX_C`=1, `resp`=0, `rsp_rdy`=0, both state machines idle, all counters 0.
- A reset asserted mid-frame forces `TX_C`=1 on the next edge and abandons any partial TX or RX byte.
- Transmit timing:
  - `TX_C` is registered.
  - The start bit of byte 0 appears in the cycle after the `snd_frm` edge.
  - Each bit lasts exactly `BAUD_DIV` cycles.
  - A full frame is 30×`BAUD_DIV` cycles; a new `snd_frm` is accepted in the first cycle after the third stop bit ends.
- Receive timing:
  - Synchronizer latency is 2 cycles.
  - `rsp_rdy` is asserted for exactly one cycle, in the cycle after the stop-bit sample of the second byte.
  - `resp` is valid in that same cycle.
- Simultaneous events: `snd_frm` accepted in the same cycle as `rsp_rdy`. The completed word is still delivered, and the counter clear applies to subsequent bytes.
- The bit timer tolerates ±2% baud mismatch at `BAUD_DIV`≥16.

## Test plan
- Reset sequence:
  - Stimulus: hold `rst`=1 for 2 cycles, then release.
  - Response: `TX_C`=1, `resp`=0x0000, `rsp_rdy`=0; no activity without stimulus.
- Command transmit:
  - Stimulus: `BAUD_DIV`=16, `cmd_data`=0x0A1234, `snd_frm` pulse.
  - Response: a line decoder sees bytes 0x0A, 0x12, 0x34 in order, each bit 16 cycles wide, frame 480 cycles; a second `snd_frm` 100 cycles in is ignored.
- Response receive:
  - Stimulus: a bench model drives bytes 0x0A then 0x5A on `RX_C`.
  - Response: `resp`=0x0A5A with a single one-cycle `rsp_rdy`; repeat with 0x05, 0xA5 to get `resp`=0x05A5.
- Echo loop:
  - Stimulus: send `cmd_data`=0x001ABC; the model answers 0x1A, 0xBC.
  - Response: `resp`[13:0]=0x1ABC.
- Error handling:
  - Glitch: a 5-cycle low glitch on `RX_C` gives no byte and no `rsp_rdy`.
  - Framing error: a byte with stop bit 0 is dropped; the following two good bytes 0x12, 0x34 give `resp`=0x1234.
- Reset mid-frame:
  - Stimulus: assert `rst` during byte 1 of a transmit.
  - Response: `TX_C`=1 the next cycle; a fresh `snd_frm` after release sends a complete, correct 3-byte frame.
